instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//   Parametrised instruction-fetch front end; replaces the fixed program_counter + 3-byte pram window pairing.
//   Prefetches program bytes from a 1-cycle-latency program RAM into a DEPTH-byte circular queue.
//   Presents the head MAX_INSTR bytes, a per-byte valid mask and the head PC to the decoder.
//   Supports variable-length consume, jump-with-flush and halt.
// PARAMETERS
//   ADDR_W     9   program address width; fetch address wraps modulo 2**ADDR_W
//   DATA_W     8   program byte width
//   DEPTH      8   queue depth in bytes; power of 2, >= MAX_INSTR+1
//   MAX_INSTR  3   max instruction length in bytes; window width
// PORTS
//   sys_clk      in   1                  clock
//   sys_rst      in   1                  reset; asynchronous, active-high
//   mem_rd_en    out  1                  program RAM read strobe
//   mem_addr     out  ADDR_W             program RAM read address
//   mem_rd_data  in   DATA_W             read data; valid exactly 1 cycle after mem_rd_en
//   jmp_en       in   1                  load jmp_addr and flush queue
//   jmp_addr     in   ADDR_W             jump target
//   halt         in   1                  freeze fetch issue and consume
//   consume      in   1                  pop instr_size bytes from head
//   instr_size   in   2                  bytes to pop, legal 1..MAX_INSTR
//   win_data     out  MAX_INSTR*DATA_W   head bytes; byte0 at [DATA_W-1:0]
//   win_valid    out  MAX_INSTR          bit i set when queue holds > i bytes
//   head_pc      out  ADDR_W             program address of win byte0
//   underrun     out  1                  1-cycle pulse: illegal or short consume rejected
// BEHAVIOUR
//   Reset:
//     - queue empty; rd/wr pointers 0; count 0; fetch_addr 0; head_pc 0.
//     - in-flight flag 0; mem_rd_en 0; mem_addr 0; win_valid 0; win_data 0; underrun 0.
//   State:
//     - queue count (0..DEPTH).
//     - fetch_addr: next address to request.
//     - inflight: 1 when a read issued last cycle returns this cycle.
//     - drop: 1 when the returning read is stale.
//   Issue rule:
//     - mem_rd_en=1, mem_addr=fetch_addr when !halt && !jmp_en && (count + inflight + 1 <= DEPTH), after this cycle's pop.
//     - fetch_addr increments on issue, wrapping 2**ADDR_W-1 -> 0.
//     - Sustained throughput: 1 byte/cycle.
//   Return:
//     - cycle after issue, mem_rd_data pushed at wr_ptr unless drop.
//     - Push with a full queue cannot occur; issue rule guarantees it (assert in sim).
//   Consume, evaluated when consume && !halt && !jmp_en:
//     - legal iff 1 <= instr_size <= MAX_INSTR and instr_size <= count.
//     - legal: rd_ptr += instr_size mod DEPTH; head_pc += instr_size mod 2**ADDR_W.
//     - illegal: no state change; underrun=1 next cycle.
//     - push and pop in the same cycle: count = count + push - instr_size.
//   Jump (highest priority):
//     - queue emptied; head_pc = fetch_addr = jmp_addr.
//     - read issued in the jump cycle is suppressed; any read returning next cycle is dropped.
//     - first new read issues the cycle after jmp_en; first byte is valid 2 cycles after jmp_en.
//     - consume in the jump cycle is ignored; no underrun.
//   Halt:
//     - no issue; no pop; an in-flight return still lands.
//     - outputs hold; jmp_en still honoured during halt.
//   Outputs:
//     - win_data/win_valid registered from the queue head; reflect state after this cycle's updates.
//     - bytes beyond count read 0.
//   Reset mid-operation:
//     - immediate return to reset state; an in-flight return after reset release is dropped.
// TESTING
//   1. Release reset, RAM[0..7]=10..17, no consume -> reads addr 0..7 back-to-back, then stall.
//      Count 8; win_data={12,11,10}; win_valid=111; head_pc=0.
//   2. Full queue; consume size 3 each cycle for 4 cycles -> head_pc 0,3,6,9.
//      No bubble after first refill; bytes match RAM order.
//   3. count=2; consume size 3 -> underrun pulse 1 cycle; count stays 2.
//      instr_size=0 -> underrun; no state change.
//   4. jmp_en with jmp_addr=0x1FE while a read is in flight -> stale byte dropped.
//      win_valid=000 next cycle; reads 0x1FE,0x1FF,0x000 (wrap); head_pc=0x1FE.
//   5. halt for 5 cycles with consume=1 -> no mem_rd_en, no pop.
//      In-flight byte captured; resumes next cycle after halt drops.
//   6. Assert sys_rst mid-stream, with consume and jmp_en same cycle -> all outputs reset asynchronously.
//      Post-release fetch restarts at 0; jmp_en beats consume.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end: prefetches program bytes from a 1-cycle-latency RAM
// into a circular byte queue and presents the head window, valid mask and head PC.
module instr_fetch_queue #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_INSTR = 3
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_rd_data,
  input  logic                          jmp_en,
  input  logic [ADDR_W-1:0]             jmp_addr,
  input  logic                          halt,
  input  logic                          consume,
  input  logic [1:0]                    instr_size,
  output logic [MAX_INSTR*DATA_W-1:0]   win_data,
  output logic [MAX_INSTR-1:0]          win_valid,
  output logic [ADDR_W-1:0]             head_pc,
  output logic                          underrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0]           queue_q [DEPTH];
  logic [PW-1:0]               rdPtr_q, rdPtr_d;
  logic [PW-1:0]               wrPtr_q, wrPtr_d;
  logic [CW-1:0]               count_q, count_d;
  logic [ADDR_W-1:0]           fetchAddr_q, fetchAddr_d;
  logic [ADDR_W-1:0]           headPc_q, headPc_d;
  logic                        inflight_q;
  logic                        underrun_q, underrun_d;
  logic [MAX_INSTR*DATA_W-1:0] winData_q, winData_d;
  logic [MAX_INSTR-1:0]        winValid_q, winValid_d;

  logic          active;
  logic          sizeLegal;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW-1:0] popCount;
  logic [CW-1:0] countAfterPop;

  // A returning read landing in a jump cycle is discarded along with the flush,
  // and reset clears inflight_q, so a stale return after reset never pushes.
  always_comb begin
    active        = !halt && !jmp_en;
    sizeLegal     = (instr_size != 2'd0) && (int'(instr_size) <= MAX_INSTR) &&
                    (CW'(instr_size) <= count_q);
    pop           = consume && active && sizeLegal;
    popCount      = pop ? CW'(instr_size) : '0;
    push          = inflight_q && !jmp_en;
    countAfterPop = count_q - popCount;
    issue         = active && !sys_rst && ((countAfterPop + CW'(inflight_q)) < CW'(DEPTH));
    underrun_d    = consume && active && !sizeLegal;

    if (jmp_en) begin
      rdPtr_d     = '0;
      wrPtr_d     = '0;
      count_d     = '0;
      headPc_d    = jmp_addr;
      fetchAddr_d = jmp_addr;
    end else begin
      rdPtr_d     = rdPtr_q + PW'(popCount);
      wrPtr_d     = wrPtr_q + PW'(push);
      count_d     = countAfterPop + CW'(push);
      headPc_d    = headPc_q + ADDR_W'(popCount);
      fetchAddr_d = issue ? fetchAddr_q + 1'b1 : fetchAddr_q;
    end
  end

  // The window is built from next-state pointers so it reflects this cycle's push and pop.
  always_comb begin
    logic [PW-1:0] idx;
    logic          byteValid;
    idx        = '0;
    byteValid  = 1'b0;
    winData_d  = '0;
    winValid_d = '0;
    for (int i = 0; i < MAX_INSTR; i++) begin
      idx           = rdPtr_d + PW'(i);
      byteValid     = count_d > CW'(i);
      winValid_d[i] = byteValid;
      if (byteValid) begin
        winData_d[i*DATA_W +: DATA_W] = (push && idx == wrPtr_q) ? mem_rd_data : queue_q[idx];
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < DEPTH; i++) queue_q[i] <= '0;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      fetchAddr_q <= '0;
      headPc_q    <= '0;
      inflight_q  <= 1'b0;
      underrun_q  <= 1'b0;
      winData_q   <= '0;
      winValid_q  <= '0;
    end else begin
      if (push) queue_q[wrPtr_q] <= mem_rd_data;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      count_q     <= count_d;
      fetchAddr_q <= fetchAddr_d;
      headPc_q    <= headPc_d;
      inflight_q  <= issue;
      underrun_q  <= underrun_d;
      winData_q   <= winData_d;
      winValid_q  <= winValid_d;
    end
  end

  assign mem_rd_en = issue;
  assign mem_addr  = fetchAddr_q;
  assign win_data  = winData_q;
  assign win_valid = winValid_q;
  assign head_pc   = headPc_q;
  assign underrun  = underrun_q;

  // The issue throttle counts the in-flight read, so a push can never meet a full queue.
  assert property (@(posedge sys_clk) disable iff (sys_rst)
                   !(push && countAfterPop == CW'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: fill, streaming consume, underrun, jump with
// wrap, halt and mid-stream reset, against hand-computed cycle-by-cycle expectations.
module tb_instr_fetch_queue;

  logic        sys_clk;
  logic        sys_rst;
  logic        mem_rd_en;
  logic [8:0]  mem_addr;
  logic [7:0]  mem_rd_data;
  logic        jmp_en;
  logic [8:0]  jmp_addr;
  logic        halt;
  logic        consume;
  logic [1:0]  instr_size;
  logic [23:0] win_data;
  logic [2:0]  win_valid;
  logic [8:0]  head_pc;
  logic        underrun;

  logic [7:0]  ram [512];
  int          compared;
  int          mismatched;

  instr_fetch_queue #(.ADDR_W(9), .DATA_W(8), .DEPTH(8), .MAX_INSTR(3)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .jmp_en(jmp_en), .jmp_addr(jmp_addr), .halt(halt),
    .consume(consume), .instr_size(instr_size),
    .win_data(win_data), .win_valid(win_valid), .head_pc(head_pc), .underrun(underrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Program RAM model: ram[a] = a + 10 (mod 256), one cycle read latency.
  initial begin
    for (int a = 0; a < 512; a++) ram[a] = 8'(a + 10);
    mem_rd_data = 8'h00;
  end
  always @(posedge sys_clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts a new cycle at the falling edge, drives inputs, then settles for comparisons.
  task automatic applyStimulus(input logic c, input logic [1:0] sz, input logic j,
                               input logic [8:0] ja, input logic h);
    @(negedge sys_clk);
    consume    = c;
    instr_size = sz;
    jmp_en     = j;
    jmp_addr   = ja;
    halt       = h;
    #1;
  endtask

  task automatic checkMem(input string tag, input logic en, input logic [8:0] addr);
    checkOutput({tag, ".rd_en"}, 32'(mem_rd_en), 32'(en));
    if (en) checkOutput({tag, ".addr"}, 32'(mem_addr), 32'(addr));
  endtask

  task automatic checkWin(input string tag, input logic [2:0] v, input logic [23:0] d,
                          input logic [8:0] pc);
    checkOutput({tag, ".valid"}, 32'(win_valid), 32'(v));
    checkOutput({tag, ".data"}, 32'(win_data), 32'(d));
    checkOutput({tag, ".pc"}, 32'(head_pc), 32'(pc));
  endtask

  logic [8:0]  t2Addr [4] = '{9'd8, 9'd9, 9'd10, 9'd11};
  logic [8:0]  t2Pc   [4] = '{9'd0, 9'd3, 9'd6, 9'd9};
  logic [23:0] t2Data [4] = '{24'h0C0B0A, 24'h0F0E0D, 24'h121110, 24'h000013};
  logic [2:0]  t2Val  [4] = '{3'b111, 3'b111, 3'b111, 3'b001};

  initial begin
    compared   = 0;
    mismatched = 0;
    sys_rst    = 1'b1;
    consume    = 1'b0;
    instr_size = 2'd0;
    jmp_en     = 1'b0;
    jmp_addr   = 9'd0;
    halt       = 1'b0;
    repeat (2) @(negedge sys_clk);
    #1;
    checkOutput("rst.rd_en", 32'(mem_rd_en), 32'd0);
    checkOutput("rst.addr", 32'(mem_addr), 32'd0);
    checkWin("rst", 3'b000, 24'h0, 9'd0);
    checkOutput("rst.underrun", 32'(underrun), 32'd0);

    // Fill: reads 0..7 back to back, then the throttle stalls at address 8.
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) applyStimulus(1'b0, 2'd0, 1'b0, 9'd0, 1'b0);
      checkMem($sformatf("fill%0d", k), k <= 7, k <= 7 ? 9'(k) : 9'd8);
    end
    checkWin("full", 3'b111, 24'h0C0B0A, 9'd0);

    // Streaming consume of 3 bytes with refill behind it.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(k < 3, 2'd3, 1'b0, 9'd0, 1'b0);
      checkMem($sformatf("stream%0d", k), 1'b1, t2Addr[k]);
      checkWin($sformatf("stream%0d", k), t2Val[k], t2Data[k], t2Pc[k]);
    end

    // Short consume, then zero-size consume, then idle.
    applyStimulus(1'b1, 2'd3, 1'b0, 9'd0, 1'b0);
    checkMem("short", 1'b1, 9'd12);
    checkWin("short", 3'b011, 24'h001413, 9'd9);
    checkOutput("short.underrun", 32'(underrun), 32'd0);
    applyStimulus(1'b1, 2'd0, 1'b0, 9'd0, 1'b0);
    checkOutput("short.underrun1", 32'(underrun), 32'd1);
    checkWin("short.hold", 3'b111, 24'h151413, 9'd9);
    applyStimulus(1'b0, 2'd0, 1'b0, 9'd0, 1'b0);
    checkOutput("zero.underrun", 32'(underrun), 32'd1);
    checkOutput("zero.pc", 32'(head_pc), 32'd9);

    // Jump to 0x1FE while a read is in flight; fetch wraps past 0x1FF.
    applyStimulus(1'b0, 2'd0, 1'b1, 9'h1FE, 1'b0);
    checkOutput("jmp.underrun", 32'(underrun), 32'd0);
    checkOutput("jmp.rd_en", 32'(mem_rd_en), 32'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 9'd0, 1'b0);
    checkMem("jmp1", 1'b1, 9'h1FE);
    checkWin("jmp1", 3'b000, 24'h0, 9'h1FE);
    applyStimulus(1'b0, 2'd0, 1'b0, 9'd0, 1'b0);
    checkMem("jmp2", 1'b1, 9'h1FF);
    checkWin("jmp2", 3'b000, 24'h0, 9'h1FE);
    applyStimulus(1'b0, 2'd0, 1'b0, 9'd0, 1'b0);
    checkMem("jmp3", 1'b1, 9'h000);
    checkWin("jmp3", 3'b001, 24'h000008, 9'h1FE);
    applyStimulus(1'b0, 2'd0, 1'b0, 9'd0, 1'b0);
    checkMem("jmp4", 1'b1, 9'h001);
    checkWin("jmp4", 3'b011, 24'h000908, 9'h1FE);

    // Halt with consume held high: no issue, no pop, in-flight byte still lands.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 2'd1, 1'b0, 9'd0, 1'b1);
      checkOutput($sformatf("halt%0d.rd_en", k), 32'(mem_rd_en), 32'd0);
      checkWin($sformatf("halt%0d", k), 3'b111, 24'h0A0908, 9'h1FE);
    end
    applyStimulus(1'b1, 2'd3, 1'b0, 9'd0, 1'b0);
    checkMem("resume", 1'b1, 9'd2);
    checkOutput("resume.underrun", 32'(underrun), 32'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 9'd0, 1'b0);
    checkWin("resume.pop", 3'b001, 24'h00000B, 9'h001);

    // Reset mid-stream with consume and jump pending; outputs clear without a clock edge.
    consume    = 1'b1;
    instr_size = 2'd1;
    jmp_en     = 1'b1;
    jmp_addr   = 9'h040;
    #1;
    sys_rst = 1'b1;
    #1;
    checkOutput("arst.rd_en", 32'(mem_rd_en), 32'd0);
    checkOutput("arst.addr", 32'(mem_addr), 32'd0);
    checkWin("arst", 3'b000, 24'h0, 9'd0);
    checkOutput("arst.underrun", 32'(underrun), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    consume = 1'b0;
    jmp_en  = 1'b0;
    #1;
    checkMem("post0", 1'b1, 9'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 9'd0, 1'b0);
    checkMem("post1", 1'b1, 9'd1);
    applyStimulus(1'b1, 2'd1, 1'b1, 9'h040, 1'b0);
    checkOutput("post2.rd_en", 32'(mem_rd_en), 32'd0);
    checkWin("post2", 3'b001, 24'h00000A, 9'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 9'd0, 1'b0);
    checkMem("post3", 1'b1, 9'h040);
    checkWin("post3", 3'b000, 24'h0, 9'h040);
    checkOutput("post3.underrun", 32'(underrun), 32'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 9'd0, 1'b0);
    checkMem("post4", 1'b1, 9'h041);
    checkOutput("post4.valid", 32'(win_valid), 32'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 9'd0, 1'b0);
    checkWin("post5", 3'b001, 24'h00004A, 9'h040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
